// File: rtl/mips_bus_arbiter.sv
// Two-master round-robin Avalon-MM arbiter in front of a single RAM slave.
// Out-of-window accesses complete locally with a sticky error flag; completed transfers are counted per master.
module mips_bus_arbiter #(
    parameter logic [31:0] BASE_ADDR    = 32'hBFC00000,
    parameter logic [31:0] WINDOW_BYTES = 32'h00010000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m0_address,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [31:0] m0_writedata,
    input  logic [3:0]  m0_byteenable,
    output logic        m0_waitrequest,
    output logic [31:0] m0_readdata,
    input  logic [31:0] m1_address,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [31:0] m1_writedata,
    input  logic [3:0]  m1_byteenable,
    output logic        m1_waitrequest,
    output logic [31:0] m1_readdata,
    output logic [31:0] s_address,
    output logic        s_read,
    output logic        s_write,
    output logic [31:0] s_writedata,
    output logic [3:0]  s_byteenable,
    input  logic        s_waitrequest,
    input  logic [31:0] s_readdata,
    output logic        err,
    output logic [31:0] err_addr,
    output logic [15:0] xfer_cnt0,
    output logic [15:0] xfer_cnt1
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GNT0 = 2'd1;
    localparam logic [1:0] ST_GNT1 = 2'd2;

    logic [1:0]  r_state;
    logic        r_last;
    logic        r_err;
    logic [31:0] r_err_addr;
    logic [15:0] r_cnt0;
    logic [15:0] r_cnt1;

    logic [1:0]  w_state_nxt;
    logic        w_req0, w_req1;
    logic        w_legal0, w_legal1;
    logic        w_block0, w_block1;
    logic        w_done0, w_done1;

    assign w_req0 = m0_read | m0_write;
    assign w_req1 = m1_read | m1_write;

    // Unsigned wrap makes addresses below the base land far outside the window.
    assign w_legal0 = (m0_address - BASE_ADDR) < WINDOW_BYTES;
    assign w_legal1 = (m1_address - BASE_ADDR) < WINDOW_BYTES;

    assign w_block0 = (r_state == ST_GNT0) && w_req0 && !w_legal0;
    assign w_block1 = (r_state == ST_GNT1) && w_req1 && !w_legal1;

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        s_address      = '0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_writedata    = '0;
        s_byteenable   = '0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        m0_readdata    = '0;
        m1_readdata    = '0;
        case (r_state)
            ST_GNT0: begin
                s_address    = m0_address;
                s_writedata  = m0_writedata;
                s_byteenable = m0_byteenable;
                if (w_block0) begin
                    m0_waitrequest = 1'b0;
                end else begin
                    s_read         = m0_read;
                    s_write        = m0_write & ~m0_read;
                    m0_waitrequest = s_waitrequest;
                    m0_readdata    = s_readdata;
                end
            end
            ST_GNT1: begin
                s_address    = m1_address;
                s_writedata  = m1_writedata;
                s_byteenable = m1_byteenable;
                if (w_block1) begin
                    m1_waitrequest = 1'b0;
                end else begin
                    s_read         = m1_read;
                    s_write        = m1_write & ~m1_read;
                    m1_waitrequest = s_waitrequest;
                    m1_readdata    = s_readdata;
                end
            end
            default: ;
        endcase
    end

    assign w_done0 = (r_state == ST_GNT0) && w_req0 && !m0_waitrequest;
    assign w_done1 = (r_state == ST_GNT1) && w_req1 && !m1_waitrequest;

    // A finishing master never re-wins immediately; the other side gets the slave next.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_req0 && w_req1) w_state_nxt = r_last ? ST_GNT0 : ST_GNT1;
                else if (w_req0)      w_state_nxt = ST_GNT0;
                else if (w_req1)      w_state_nxt = ST_GNT1;
            end
            ST_GNT0: begin
                if (w_done0)      w_state_nxt = w_req1 ? ST_GNT1 : ST_IDLE;
                else if (!w_req0) w_state_nxt = ST_IDLE;
            end
            ST_GNT1: begin
                if (w_done1)      w_state_nxt = w_req0 ? ST_GNT0 : ST_IDLE;
                else if (!w_req1) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_last     <= 1'b1;
            r_err      <= 1'b0;
            r_err_addr <= '0;
            r_cnt0     <= '0;
            r_cnt1     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state <= w_state_nxt;
            if (w_done0) begin
                r_last <= 1'b0;
                if (r_cnt0 != 16'hFFFF) r_cnt0 <= r_cnt0 + 16'd1;
            end
            if (w_done1) begin
                r_last <= 1'b1;
                if (r_cnt1 != 16'hFFFF) r_cnt1 <= r_cnt1 + 16'd1;
            end
            if (w_block0 || w_block1) begin
                r_err <= 1'b1;
                if (!r_err) r_err_addr <= w_block1 ? m1_address : m0_address;
            end
        end
    end

    assign err       = r_err;
    assign err_addr  = r_err_addr;
    assign xfer_cnt0 = r_cnt0;
    assign xfer_cnt1 = r_cnt1;

endmodule
